// File: rtl/seq_pkg.sv
// Shared constants for the sequence-detector path: serializer state
// encodings, the default word width, and the detector's state constants.
package seq_pkg;

  // Default serializer word width in bits.
  localparam int SEQ_WIDTH = 8;

  // Serializer FSM states (PARITY only reachable with SERIAL_PARITY_EN).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_PARITY = 2'b10
  } feed_state_e;

  // Overlapping Moore "1101" detector states: S<n> = n pattern bits matched.
  typedef enum logic [2:0] {
    DET_S0 = 3'd0,
    DET_S1 = 3'd1,
    DET_S2 = 3'd2,
    DET_S3 = 3'd3,
    DET_S4 = 3'd4
  } det_state_e;

  // Even parity over a 32-bit zero-extended word.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_bit_feeder_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module bit_down_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Counter register: load has priority; decrement only while nonzero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on a valid/ready
// handshake and emits them MSB first, one bit per clock, with no gap
// between back-to-back words.
// Optional macro SERIAL_PARITY_EN appends one even-parity bit per word.
module serial_bit_feeder
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  feed_state_e      state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             busy_q, busy_d;
  logic             ready_s;
  logic             accept_s;
  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic             cnt_zero_s;
`ifdef SERIAL_PARITY_EN
  logic             par_q, par_d;
`endif

  bit_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load_s),
    .load_val_i (LAST_IDX),
    .dec_i      (cnt_dec_s),
    .zero_o     (cnt_zero_s)
  );

  // Ready decode from state and bit counter only (never from din_valid).
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      ST_IDLE:   ready_s = 1'b1;
`ifdef SERIAL_PARITY_EN
      ST_SHIFT:  ready_s = 1'b0;
      ST_PARITY: ready_s = 1'b1;
`else
      ST_SHIFT:  ready_s = cnt_zero_s;
`endif
      default:   ready_s = 1'b0;
    endcase
  end

  assign din_ready = ~reset & ready_s;
  assign accept_s  = din_valid & din_ready;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
`ifdef SERIAL_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d    = ST_SHIFT;
          sr_d       = din;
          cnt_load_s = 1'b1;
`ifdef SERIAL_PARITY_EN
          par_d      = even_parity(32'(din));
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
        if (!cnt_zero_s) begin
          cnt_dec_s = 1'b1;
`ifdef SERIAL_PARITY_EN
        end else begin
          state_d = ST_PARITY;
        end
`else
        end else if (accept_s) begin
          sr_d       = din;
          cnt_load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
`endif
      end
`ifdef SERIAL_PARITY_EN
      ST_PARITY: begin
        if (accept_s) begin
          state_d    = ST_SHIFT;
          sr_d       = din;
          cnt_load_s = 1'b1;
          par_d      = even_parity(32'(din));
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    busy_d       = (state_d != ST_IDLE);
    case (state_d)
      ST_SHIFT: begin
        sout_d       = sr_d[WIDTH-1];
        sout_valid_d = 1'b1;
      end
`ifdef SERIAL_PARITY_EN
      ST_PARITY: begin
        sout_d       = par_d;
        sout_valid_d = 1'b1;
      end
`endif
      default: begin
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
      end
    endcase
  end

  // State, shift register and output registers; reset discards any word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sr_q         <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
`ifdef SERIAL_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Self-checking bench for serial_bit_feeder: directed vector tables,
// hand-written reset and detector sequences, and randomized traffic
// checked against a queue-based model of the emitted bit stream.
module tb_serial_bit_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sout;
  logic         sout_valid;
  logic         busy;

  int checks = 0;
  int passed = 0;

  // Model: bits still to be emitted, front = bit currently on sout.
  bit model_q[$];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         e_rdy;
    logic         e_sout;
    logic         e_val;
    logic         e_busy;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_push(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) model_q.push_back(w[i]);
`ifdef SERIAL_PARITY_EN
    model_q.push_back(^w);
`endif
  endtask

  task automatic add(input logic v, input logic [W-1:0] d, input logic r,
                     input logic s, input logic val, input logic b);
    vec_t e;
    e.v = v; e.d = d; e.e_rdy = r; e.e_sout = s; e.e_val = val; e.e_busy = b;
    tbl.push_back(e);
  endtask

  // Reset with immediate (asynchronous) checks of all outputs.
  task automatic do_reset();
    din_valid = 1'b0;
    din = '0;
    reset = 1'b1;
    #1;
    chk("rst_sout", sout, 1'b0);
    chk("rst_sout_valid", sout_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_din_ready", din_ready, 1'b0);
    model_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_din_ready", din_ready, 1'b1);
  endtask

  // One clock of traffic checked against the stream model.
  task automatic cycle_model(input logic v, input logic [W-1:0] d, output logic acc);
    logic rdy_exp;
    din_valid = v;
    din = d;
    #1;
    rdy_exp = (model_q.size() <= 1);
    chk("din_ready", din_ready, rdy_exp);
    acc = v && rdy_exp;
    @(posedge clk);
    if (model_q.size() > 0) void'(model_q.pop_front());
    if (acc) model_push(d);
    #1;
    chk("sout_valid", sout_valid, model_q.size() > 0);
    chk("busy", busy, model_q.size() > 0);
    chk("sout", sout, (model_q.size() > 0) ? model_q[0] : 1'b0);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      din_valid = tbl[i].v;
      din = tbl[i].d;
      #1;
      chk({name, "_ready"}, din_ready, tbl[i].e_rdy);
      @(posedge clk);
      #1;
      chk({name, "_sout"}, sout, tbl[i].e_sout);
      chk({name, "_valid"}, sout_valid, tbl[i].e_val);
      chk({name, "_busy"}, busy, tbl[i].e_busy);
    end
    tbl.delete();
  endtask

  initial begin
    logic [W-1:0] w, w2;
    logic acc;
    logic hold_v;
    logic [W-1:0] hold_d;
    bit cap[$];
    int hits;
    int ends[$];

    do_reset();

    // Single word 0xD3, valid for one cycle, then idle.
    w = 8'hD3;
    add(1'b1, w, 1'b1, w[7], 1'b1, 1'b1);
    for (int i = 6; i >= 0; i--) add(1'b0, 8'h00, 1'b0, w[i], 1'b1, 1'b1);
`ifdef SERIAL_PARITY_EN
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
`endif
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    run_table("d3");

    // Back-to-back 0xB5 then 0x6C held valid: contiguous stream.
    w = 8'hB5;
    w2 = 8'h6C;
    add(1'b1, w, 1'b1, w[7], 1'b1, 1'b1);
    for (int i = 6; i >= 0; i--) add(1'b1, w2, 1'b0, w[i], 1'b1, 1'b1);
`ifdef SERIAL_PARITY_EN
    add(1'b1, w2, 1'b0, 1'b1, 1'b1, 1'b1);
`endif
    add(1'b1, w2, 1'b1, w2[7], 1'b1, 1'b1);
    for (int i = 6; i >= 0; i--) add(1'b0, 8'h00, 1'b0, w2[i], 1'b1, 1'b1);
`ifdef SERIAL_PARITY_EN
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    run_table("b5_6c");

`ifdef SERIAL_PARITY_EN
    // 0x03 has two ones: parity bit is 0.
    w = 8'h03;
    add(1'b1, w, 1'b1, w[7], 1'b1, 1'b1);
    for (int i = 6; i >= 0; i--) add(1'b0, 8'h00, 1'b0, w[i], 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    run_table("p03");
`endif

    // Asynchronous reset after three bits of 0xFF, then a clean 0x81.
    do_reset();
    cycle_model(1'b1, 8'hFF, acc);
    cycle_model(1'b0, 8'h00, acc);
    cycle_model(1'b0, 8'h00, acc);
    chk("ff_mid_busy", busy, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_sout_valid", sout_valid, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_sout", sout, 1'b0);
    chk("async_din_ready", din_ready, 1'b0);
    model_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle_model(1'b1, 8'h81, acc);
    chk("w81_accept", acc, 1'b1);
    for (int i = 0; i < W + 2; i++) cycle_model(1'b0, 8'h00, acc);

    // 0x6D into an overlapping 1101 matcher: two hits, ending at bits 4 and 7.
    do_reset();
    cycle_model(1'b1, 8'h6D, acc);
    if (sout_valid) cap.push_back(sout);
    for (int i = 0; i < W + 2; i++) begin
      cycle_model(1'b0, 8'h00, acc);
      if (sout_valid) cap.push_back(sout);
    end
    hits = 0;
    for (int i = 3; i < W && i < cap.size(); i++) begin
      if (cap[i-3] == 1'b1 && cap[i-2] == 1'b1 && cap[i-1] == 1'b0 && cap[i] == 1'b1) begin
        hits++;
        ends.push_back(i);
      end
    end
    chk_int("det_hits", hits, 2);
    chk_int("det_end0", (ends.size() > 0) ? ends[0] : -1, 4);
    chk_int("det_end1", (ends.size() > 1) ? ends[1] : -1, 7);

    // Randomized traffic with upstream hold-until-accepted and rare resets.
    do_reset();
    hold_v = 1'b0;
    hold_d = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        hold_v = 1'b0;
      end else begin
        if (!hold_v) begin
          hold_v = ($urandom_range(0, 3) != 0);
          hold_d = W'($urandom);
        end
        cycle_model(hold_v, hold_d, acc);
        if (acc) hold_v = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
